fb_port_arbiter: RTL

FB_PORT_ARBITER -- requirements
Module: fb_port_arbiter

---
 rtl/fb_port_arbiter.sv | 117 +++++++++++
 1 files changed

// File: rtl/fb_port_arbiter.sv
// Single-port framebuffer RAM arbiter: VGA scan-out reads take priority, CPU accesses
// fill the gaps, and a starvation counter forces a CPU grant by dropping a VGA read.
`timescale 1ns/1ps

module fb_port_arbiter #(
    parameter int ADDR_W       = 18,
    parameter int MEM_LAT      = 1,
    parameter int STARVE_LIMIT = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic [7:0]        vga_data,
    output logic              vga_valid,
    output logic              vga_miss,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic              cpu_gnt,
    output logic [7:0]        cpu_rdata,
    output logic              cpu_rvalid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic [15:0]       miss_count
);

    typedef enum logic [1:0] {IDLE, VGA, CPU, FORCE} state_t;
    typedef enum logic [1:0] {TAG_NONE, TAG_VGA, TAG_CPU} tag_t;

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    state_t     state;
    state_t     decision;
    logic [7:0] starve;
    tag_t       tag_issue;
    tag_t       tag_pipe [MEM_LAT];
    logic [7:0] vga_hold;
    logic [7:0] cpu_hold;

    always_comb begin
        // NOTE: assign a default before any branch so no path leaves the signal unassigned and infers a latch.
        decision = IDLE;
        if (cpu_req && starve == LIMIT) decision = FORCE;
        else if (vga_req)                decision = VGA;
        else if (cpu_req)                decision = CPU;
    end

    // The requester must see grant/miss in the decision cycle itself, so these are
    // combinational; gating with reset_n keeps them low while reset is asserted.
    assign cpu_gnt  = reset_n && (decision == CPU || decision == FORCE);
    assign vga_miss = reset_n && decision == FORCE && vga_req;

    // Owner of the access currently on the RAM bus; CPU writes return nothing.
    always_comb begin
        tag_issue = TAG_NONE;
        if (state == VGA)
            tag_issue = TAG_VGA;
        else if ((state == CPU || state == FORCE) && !mem_we)
            tag_issue = TAG_CPU;
    end

    assign vga_valid  = tag_pipe[MEM_LAT-1] == TAG_VGA;
    assign cpu_rvalid = tag_pipe[MEM_LAT-1] == TAG_CPU;
    assign vga_data   = vga_valid  ? mem_rdata : vga_hold;
    assign cpu_rdata  = cpu_rvalid ? mem_rdata : cpu_hold;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            starve     <= '0;
            miss_count <= '0;
            mem_addr   <= '0;
            mem_we     <= 1'b0;
            mem_wdata  <= '0;
            vga_hold   <= '0;
            cpu_hold   <= '0;
            // NOTE: unlike a data array, the tag pipe is reset so reads in flight at reset never raise a valid.
            for (int i = 0; i < MEM_LAT; i++) tag_pipe[i] <= TAG_NONE;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values, independent of statement order.
            state <= decision;

            case (decision)
                VGA: begin
                    mem_addr <= vga_addr;
                    mem_we   <= 1'b0;
                end
                CPU, FORCE: begin
                    mem_addr  <= cpu_addr;
                    mem_we    <= cpu_we;
                    mem_wdata <= cpu_wdata;
                end
                IDLE: mem_we <= 1'b0;
                default: mem_we <= 1'b0;
            endcase

            if (!cpu_req || cpu_gnt)
                starve <= '0;
            else if (starve != LIMIT)
                starve <= starve + 8'd1;

            if (vga_miss && miss_count != 16'hFFFF)
                miss_count <= miss_count + 16'd1;

            tag_pipe[0] <= tag_issue;
            for (int i = 1; i < MEM_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];

            if (vga_valid)  vga_hold <= mem_rdata;
            if (cpu_rvalid) cpu_hold <= mem_rdata;
        end
    end

endmodule
